lut5_reconfig_ctrl: RTL and testbench
=====================================

Name: lut5_reconfig_ctrl

Overview:
- Run-time reconfiguration controller for a 5-input, 32-entry lookup table.
- Accepts a 32-bit truth-table word over a valid/ready handshake.
- Serialises the word one bit per cycle into a staging table, in the same load order as a serially configured LUT primitive, then atomically commits it to the active table.
- The lookup output O always reads the active table, so lookups never see a partial table. Sits between the config/management path and LUT-based datapath logic.

Parameters:
- INIT, 32'h00000000: table loaded into active and staging registers on reset; bit k is the output for address k.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- CFG_DATA  input  32  new truth table; bit k is the output for address k
- CFG_VALID  input  1  CFG_DATA valid
- CFG_READY  output  1  controller can accept a word
- CFG_CE  input  1  shift enable; low stalls serial loading
- ADR0..ADR4  input  1 each  lookup address, ADR0 = LSB
- O  output  1  active_table[{ADR4,ADR3,ADR2,ADR1,ADR0}], combinational
- CDO  output  1  staging[31], serial cascade out for chaining a downstream LUT
- BUSY  output  1  load in progress (state != IDLE)
- DONE  output  1  one-cycle pulse in the commit cycle

Behaviour:
- Registers:
  - active[31:0] and staging[31:0], both reset to INIT
  - word[31:0], the captured CFG_DATA
  - cnt[5:0]
  - state in {IDLE, SHIFT, COMMIT}
- Reset (RST=1 at a clock edge):
  - state <= IDLE, cnt <= 0, active <= INIT, staging <= INIT, DONE <= 0.
  - A handshake in the same cycle is ignored.
  - After the reset cycle: CFG_READY=1, BUSY=0, DONE=0, CDO=INIT[31], O=INIT[addr].
- CFG_READY = (state==IDLE). BUSY = (state!=IDLE).
- IDLE:
  - On CFG_VALID & CFG_READY (accept edge T): word <= CFG_DATA, cnt <= 0, go to SHIFT.
  - CFG_CE is ignored in IDLE.
- SHIFT, per edge with CFG_CE=1:
  - staging <= {staging[30:0], word[31-cnt]}, i.e. MSB first.
  - cnt <= cnt+1.
  - After the shift with cnt==31, go to COMMIT.
- SHIFT with CFG_CE=0: staging, cnt and state all hold.
- Unstalled load timing: shifts occur on edges T+1..T+32. After edge T+32, staging == word and state=COMMIT.
- COMMIT:
  - DONE=1 for this single cycle.
  - At the next edge: active <= staging, state <= IDLE.
  - CFG_CE does not stall COMMIT.
- Load latency: O reflects the new table 34 cycles after the accept edge; CFG_READY=1 again in that same cycle.
- O:
  - Purely combinational from active and ADR*.
  - Unchanged by staging activity.
  - Changes only at the commit edge or on reset.
- CDO:
  - Equals staging[31] at all times.
  - During a load it emits the previous staging contents MSB first (old table bits 31..0 over the 32 shifts).
- CFG_VALID while BUSY: not accepted, and CFG_DATA is not sampled. The master must hold VALID/DATA until the handshake.
- Back-to-back: a word presented while IDLE is accepted on the first IDLE edge. Minimum spacing between accepts is 34 cycles.
- Reset mid-SHIFT or mid-COMMIT:
  - Load aborts, no DONE.
  - active and staging return to INIT; the partially loaded word is lost.
- cnt is 6 bits wide; the wrap from 31 is never used because the state changes instead.

Test Plan:
- Reset with INIT=32'h80000001: addr 0 -> O=1; addr 31 -> O=1; addr 5 -> O=0; CFG_READY=1, BUSY=0, DONE=0.
- Load 32'hDEADBEEF with CFG_CE=1, starting from INIT=0:
  - O at addr 0 stays 0 through cycle T+33.
  - DONE is high only in cycle T+33.
  - From T+34, addr 0 -> O=1, addr 4 -> O=0, addr 31 -> O=1, and CFG_READY=1.
- CDO chaining: with staging=32'hA5A5A5A5, load any word; CDO over shift edges 1..32 equals 1,0,1,0,0,1,0,1,... (A5A5A5A5 MSB first); after the last shift, staging == word.
- CE stall: drop CFG_CE for 5 cycles mid-SHIFT -> cnt and staging frozen, DONE delayed to T+38, final table correct.
- Busy-reject plus back-to-back:
  - Present 32'h12345678 with VALID held while BUSY -> not accepted until the cycle CFG_READY rises.
  - The second load then completes, and O matches 32'h12345678 at all 32 addresses.
- Reset mid-load: RST at shift 17 of 32'hFFFFFFFF with INIT=0 -> no DONE, O=0 at all addresses, CDO=0, CFG_READY=1 after the reset cycle.

Source files
------------

// File: rtl/lut5_reconfig_ctrl.sv
// Reconfigurable 5-input LUT: a 32-bit table arrives over valid/ready and is shifted MSB first into staging, then committed atomically.
// A new table is visible on O 34 cycles after the accept edge; CFG_READY is low for that whole load, and CFG_CE low stalls only the shift phase.
module lut5_reconfig_ctrl #(
  parameter logic [31:0] INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] CFG_DATA,
  input  logic        CFG_VALID,
  output logic        CFG_READY,
  input  logic        CFG_CE,
  input  logic        ADR0,
  input  logic        ADR1,
  input  logic        ADR2,
  input  logic        ADR3,
  input  logic        ADR4,
  output logic        O,
  output logic        CDO,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] active;
  logic [31:0] staging;
  logic [31:0] word;
  logic [5:0]  cnt;
  logic        accept;
  logic        shift_en;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (CFG_VALID) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (CFG_CE) begin
          shift_en = 1'b1;
          if (cnt == 6'd31) state_nxt = COMMIT;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      active  <= INIT;
      staging <= INIT;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word <= CFG_DATA;
        cnt  <= 6'd0;
      end
      // Same bit order as a serially configured LUT primitive: MSB enters first.
      if (shift_en) begin
        staging <= {staging[30:0], word[5'd31 - cnt[4:0]]};
        cnt     <= cnt + 6'd1;
      end
      if (state == COMMIT) active <= staging;
    end
  end

  assign CFG_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign DONE      = (state == COMMIT);
  assign CDO       = staging[31];
  assign O         = active[{ADR4, ADR3, ADR2, ADR1, ADR0}];

endmodule

// File: tb/tb_lut5_reconfig_ctrl.sv
// Directed and randomized checks of lut5_reconfig_ctrl against a table-level model of load, commit and reset.
module tb_lut5_reconfig_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ce;
  logic [4:0]  adr;
  logic        cfg_ready, o, cdo, busy, done;
  logic        cfg_ready2, o2, cdo2, busy2, done2;

  int vectors = 0;
  int miscompares = 0;

  // Model state: the committed table and the staging contents at the last commit/reset.
  logic [31:0] m_active;
  logic [31:0] m_staging;

  always #5 clk = ~clk;

  lut5_reconfig_ctrl #(.INIT(32'h00000000)) dut (
    .CLK(clk), .RST(rst), .CFG_DATA(cfg_data), .CFG_VALID(cfg_valid), .CFG_READY(cfg_ready),
    .CFG_CE(cfg_ce), .ADR0(adr[0]), .ADR1(adr[1]), .ADR2(adr[2]), .ADR3(adr[3]), .ADR4(adr[4]),
    .O(o), .CDO(cdo), .BUSY(busy), .DONE(done)
  );

  lut5_reconfig_ctrl #(.INIT(32'h80000001)) dut_init (
    .CLK(clk), .RST(rst), .CFG_DATA(cfg_data), .CFG_VALID(1'b0), .CFG_READY(cfg_ready2),
    .CFG_CE(cfg_ce), .ADR0(adr[0]), .ADR1(adr[1]), .ADR2(adr[2]), .ADR3(adr[3]), .ADR4(adr[4]),
    .O(o2), .CDO(cdo2), .BUSY(busy2), .DONE(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Staging contents after k MSB-first shifts of w into old.
  function automatic logic [31:0] stg_after(input logic [31:0] old, input logic [31:0] w, input int k);
    logic [63:0] cat;
    cat = {old, w} << k;
    return cat[63:32];
  endfunction

  task automatic check_table(input string tag, input logic [31:0] exp);
    for (int a = 0; a < 32; a++) begin
      adr = a[4:0];
      #1;
      chk($sformatf("%s[%0d]", tag, a), {31'd0, o}, {31'd0, exp[a]});
    end
    step();
  endtask

  // One full load. stall_at/stall_len: hold CE low for stall_len cycles once stall_at shifts are done.
  // rand_ce randomizes CE during shifting; rst_at >= 0 pulses reset once rst_at shifts are done.
  // next_word, if hold_next, is presented with VALID held while the controller is busy.
  task automatic load(input logic [31:0] w, input int stall_at, input int stall_len, input bit rand_ce,
                      input int rst_at, input bit hold_next, input logic [31:0] next_word,
                      output int done_edge);
    int k, cyc, stalled;
    logic [31:0] old;
    old = m_staging;
    done_edge = -1;
    cfg_data  = w;
    cfg_valid = 1'b1;
    step();
    chk("accept_ready_low", {31'd0, cfg_ready}, 32'd0);
    chk("accept_busy", {31'd0, busy}, 32'd1);
    if (hold_next) cfg_data = next_word;
    else cfg_valid = 1'b0;
    k = 0; cyc = 0; stalled = 0;
    while (k < 32 && cyc < 200) begin
      if (k == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_active  = 32'h0;
        m_staging = 32'h0;
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cdo", {31'd0, cdo}, 32'd0);
        cfg_valid = 1'b0;
        return;
      end
      if (k == stall_at && stalled < stall_len) begin
        cfg_ce = 1'b0;
        stalled++;
      end else if (rand_ce) begin
        cfg_ce = ($urandom_range(0, 2) != 0);
      end else begin
        cfg_ce = 1'b1;
      end
      step();
      cyc++;
      if (cfg_ce) k++;
      chk($sformatf("cdo_k%0d", k), {31'd0, cdo}, {31'd0, stg_after(old, w, k)[31]});
      chk("o_during_load", {31'd0, o}, {31'd0, m_active[adr]});
      chk("done_timing", {31'd0, done}, {31'd0, (k == 32)});
      chk("busy_during_load", {31'd0, busy}, 32'd1);
    end
    if (cyc >= 200) chk("load_timeout", cyc, 32'd0);
    done_edge = cyc;
    // CE low must not stall the commit.
    cfg_ce = 1'b0;
    step();
    m_active  = w;
    m_staging = w;
    chk("post_commit_ready", {31'd0, cfg_ready}, 32'd1);
    chk("post_commit_busy", {31'd0, busy}, 32'd0);
    chk("post_commit_done", {31'd0, done}, 32'd0);
    chk("post_commit_o", {31'd0, o}, {31'd0, m_active[adr]});
    cfg_ce = 1'b1;
  endtask

  initial begin
    int de;
    logic [31:0] w;
    rst = 1'b1; cfg_data = 32'h0; cfg_valid = 1'b1; cfg_ce = 1'b1; adr = 5'd0;
    step();
    step();
    rst = 1'b0;
    cfg_valid = 1'b0;
    m_active = 32'h0;
    m_staging = 32'h0;

    // Reset values, including the INIT=32'h80000001 instance.
    chk("reset_ready", {31'd0, cfg_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_cdo", {31'd0, cdo}, 32'd0);
    chk("init_ready", {31'd0, cfg_ready2}, 32'd1);
    chk("init_busy", {31'd0, busy2}, 32'd0);
    chk("init_done", {31'd0, done2}, 32'd0);
    chk("init_cdo", {31'd0, cdo2}, 32'd1);
    adr = 5'd0;  #1; chk("init_o_a0", {31'd0, o2}, 32'd1);
    adr = 5'd31; #1; chk("init_o_a31", {31'd0, o2}, 32'd1);
    adr = 5'd5;  #1; chk("init_o_a5", {31'd0, o2}, 32'd0);
    step();

    // DEADBEEF unstalled: DONE only after edge T+32, new table from edge T+33.
    adr = 5'd0;
    load(32'hDEADBEEF, -1, 0, 1'b0, -1, 1'b0, 32'h0, de);
    chk("deadbeef_done_edge", de, 32'd32);
    chk("deadbeef_a0", {31'd0, o}, 32'd1);
    adr = 5'd4;  #1; chk("deadbeef_a4", {31'd0, o}, 32'd0);
    adr = 5'd31; #1; chk("deadbeef_a31", {31'd0, o}, 32'd1);
    step();
    check_table("deadbeef_tbl", 32'hDEADBEEF);

    // Staging becomes A5A5A5A5, then the next load streams it out on CDO.
    load(32'hA5A5A5A5, -1, 0, 1'b0, -1, 1'b0, 32'h0, de);
    load(32'h0F1E2D3C, -1, 0, 1'b0, -1, 1'b0, 32'h0, de);
    check_table("chain_tbl", 32'h0F1E2D3C);

    // Five-cycle CE stall mid-shift delays DONE by five cycles.
    load(32'hC3A50F96, 12, 5, 1'b0, -1, 1'b0, 32'h0, de);
    chk("stall_done_edge", de, 32'd37);
    check_table("stall_tbl", 32'hC3A50F96);

    // Busy-reject then back-to-back accept on the first IDLE edge.
    load(32'h55AA33CC, -1, 0, 1'b0, -1, 1'b1, 32'h12345678, de);
    load(32'h12345678, -1, 0, 1'b0, -1, 1'b0, 32'h0, de);
    check_table("b2b_tbl", 32'h12345678);

    // Randomized loads with random CE and lookup address.
    for (int n = 0; n < 6; n++) begin
      w = $urandom;
      adr = 5'($urandom_range(0, 31));
      load(w, -1, 0, 1'b1, -1, 1'b0, 32'h0, de);
      check_table($sformatf("rand%0d_tbl", n), w);
    end

    // Reset after 16 shifts of all-ones: load aborts, table back to INIT.
    adr = 5'd7;
    load(32'hFFFFFFFF, -1, 0, 1'b0, 16, 1'b0, 32'h0, de);
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      step();
    end
    check_table("abort_tbl", 32'h00000000);
    chk("abort_cdo", {31'd0, cdo}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
